// File: rtl/compute_y_sequencer.sv
// compute_y_sequencer: sweeps every (a,b) pair with a in 0..a_max and b in 0..b_max, b fastest, through an external
// compute_y stage, and queues {a,b,y} results in a first-word fall-through FIFO.
// Latency 3 + compute_y latency cycles per point when the FIFO has room; done pulses the cycle busy falls.
// Backpressure: a full FIFO holds the sweep in STORE with no further cy_start; rd_en on an empty FIFO is ignored.
// Optional WAIT timeout abort: define COMPUTE_Y_SEQ_TIMEOUT_EN (then TIMEOUT is used; otherwise err is tied low).
module compute_y_sequencer #(
    parameter int DEPTH   = 16,   // power of two, at least 2
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     go,
    input  logic [7:0]               a_max,
    input  logic [7:0]               b_max,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     cy_start,
    output logic [7:0]               cy_a,
    output logic [7:0]               cy_b,
    input  logic [7:0]               cy_y,
    input  logic                     cy_ready,
    input  logic                     rd_en,
    output logic [23:0]              rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        STORE = 3'd3,
        NEXT  = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // Sweep limits latched on an accepted go, so a_max/b_max may change mid-sweep.
    logic [7:0] a_lim;
    logic [7:0] b_lim;
    logic [7:0] y_q;

    // FSM decode strobes.
    logic load;
    logic capture;
    logic push;
    logic advance;
    logic sweep_end;
    logic timeout_hit;
    logic wait_expired;
    logic last_a;
    logic last_b;

    // FIFO storage and bookkeeping.
    logic [23:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          pop;

    assign last_a   = (cy_a == a_lim);
    assign last_b   = (cy_b == b_lim);
    assign full     = (count == CW'(DEPTH));
    assign pop      = rd_en && (count != '0);
    assign busy     = (state != IDLE);
    assign rd_valid = (count != '0);
    // Empty FIFO presents zero rather than stale storage.
    assign rd_data  = rd_valid ? mem[rd_ptr] : 24'd0;

    // State register; reset abandons any sweep in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        state_nxt   = state;
        cy_start    = 1'b0;
        load        = 1'b0;
        capture     = 1'b0;
        push        = 1'b0;
        advance     = 1'b0;
        sweep_end   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    load      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                cy_start  = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cy_ready) begin
                    capture   = 1'b1;
                    state_nxt = STORE;
                end else if (wait_expired) begin
                    // Aborted point is dropped: nothing is pushed.
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            STORE: begin
                // Full is judged on registered count, so a pop this cycle
                // only makes room for a push on the following cycle.
                if (!full) begin
                    push      = 1'b1;
                    state_nxt = NEXT;
                end
            end
            NEXT: begin
                if (last_a && last_b) begin
                    sweep_end = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    advance   = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand walk: b counts fastest and wraps to 0 when it reaches b_lim.
    always_ff @(posedge clk) begin
        if (rst) begin
            cy_a  <= 8'd0;
            cy_b  <= 8'd0;
            a_lim <= 8'd0;
            b_lim <= 8'd0;
        end else if (load) begin
            cy_a  <= 8'd0;
            cy_b  <= 8'd0;
            a_lim <= a_max;
            b_lim <= b_max;
        end else if (advance) begin
            if (last_b) begin
                cy_b <= 8'd0;
                cy_a <= cy_a + 8'd1;
            end else begin
                cy_b <= cy_b + 8'd1;
            end
        end
    end

    // Hold the compute_y result until it can be pushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= 8'd0;
        end else if (capture) begin
            y_q <= cy_y;
        end
    end

    // done is a registered pulse, coincident with the first IDLE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= sweep_end || timeout_hit;
        end
    end

`ifdef COMPUTE_Y_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt;

    // Counts WAIT cycles; it is zero on the first WAIT cycle of every point.
    always_ff @(posedge clk) begin
        if (rst || (state != WAIT)) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign wait_expired = (wait_cnt == TW'(TIMEOUT - 1));

    // Sticky timeout flag, cleared only by the next accepted go.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (load) begin
            err <= 1'b0;
        end else if (timeout_hit) begin
            err <= 1'b1;
        end
    end
`else
    assign wait_expired = 1'b0;
    assign err          = 1'b0;
`endif

    // FIFO storage write; contents persist across sweeps.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cy_a, cy_b, y_q};
        end
    end

    // FIFO pointers wrap naturally at DEPTH; occupancy tracks push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_compute_y_sequencer.sv
// Bench for compute_y_sequencer: directed steps plus randomized sweeps against a reference model.
// A behavioural compute_y (y = a*a + floor(cbrt(b))) answers cy_start after a configurable latency.
// Expected FIFO traffic is the full b-fastest point list built up front; a reader pops and compares.
module tb_compute_y_sequencer;

`ifdef COMPUTE_Y_SEQ_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [7:0]  a_max;
    logic [7:0]  b_max;
    logic        busy;
    logic        done;
    logic        err;
    logic        cy_start;
    logic [7:0]  cy_a;
    logic [7:0]  cy_b;
    logic [7:0]  cy_y = 8'd0;
    logic        cy_ready = 1'b0;
    logic        rd_en = 1'b0;
    logic [23:0] rd_data;
    logic        rd_valid;
    logic [4:0]  count;

    always #5 clk = ~clk;

    compute_y_sequencer #(.DEPTH(16), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .a_max    (a_max),
        .b_max    (b_max),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .cy_start (cy_start),
        .cy_a     (cy_a),
        .cy_b     (cy_b),
        .cy_y     (cy_y),
        .cy_ready (cy_ready),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (count)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] fy(input int a, input int b);
        int c;
        c = 0;
        while ((c + 1) * (c + 1) * (c + 1) <= b) c++;
        return 8'(a * a + c);
    endfunction

    // Reference queues: operands expected at each cy_start, entries expected at the FIFO head.
    logic [15:0] op_q [$];
    logic [23:0] exp_q [$];

    // compute_y model configuration.
    int lat        = 1;
    bit no_resp    = 1'b0;
    bit iv_chk     = 1'b0;
    int y_force    = -1;
    int last_start = -1;
    int starts     = 0;

    // Reader configuration and observations.
    int          rd_budget = 0;
    int          rd_pct    = 100;
    logic [23:0] last_pop  = 24'd0;

    int done_cnt = 0;

    // Behavioural compute_y: checks operands at start, holds them checked, answers after lat cycles.
    int          pend = -1;
    logic [7:0]  la = 8'd0;
    logic [7:0]  lb = 8'd0;
    logic [16:0] exp_op;
    always @(negedge clk) begin
        cy_ready = 1'b0;
        if (rst) begin
            pend = -1;
        end else begin
            if (pend > 0) begin
                chk("operand_hold", {cy_a, cy_b}, {la, lb});
                pend--;
                if (pend == 0) begin
                    cy_ready = 1'b1;
                    cy_y     = (y_force >= 0) ? 8'(y_force) : fy(int'(la), int'(lb));
                    pend     = -1;
                end
            end
            if (cy_start) begin
                starts++;
                exp_op = (op_q.size() > 0) ? {1'b0, op_q.pop_front()} : 17'h10000;
                chk("start_operands", {1'b0, cy_a, cy_b}, exp_op);
                if (iv_chk && last_start >= 0) chk("point_cycles", cyc - last_start, lat + 3);
                last_start = cyc;
                la = cy_a;
                lb = cy_b;
                if (!no_resp) pend = lat;
            end
        end
    end

    // Reader: pops with probability rd_pct while budget remains, comparing against the reference.
    logic [24:0] exp_rd;
    always @(negedge clk) begin
        rd_en = 1'b0;
        if (!rst && rd_budget > 0 && $urandom_range(0, 99) < rd_pct) begin
            rd_en = 1'b1;
            if (rd_valid) begin
                exp_rd = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 25'h1000000;
                chk("rd_data", {1'b0, rd_data}, exp_rd);
                last_pop = rd_data;
                rd_budget--;
            end
        end
    end

    always @(negedge clk) if (done) done_cnt++;

    task automatic load_sweep(input int am, input int bm, input bit store);
        for (int a = 0; a <= am; a++) begin
            for (int b = 0; b <= bm; b++) begin
                op_q.push_back({8'(a), 8'(b)});
                if (store) exp_q.push_back({8'(a), 8'(b), (y_force >= 0) ? 8'(y_force) : fy(a, b)});
            end
        end
    endtask

    task automatic start_sweep(input int am, input int bm);
        last_start = -1;
        @(negedge clk);
        go = 1'b1; a_max = 8'(am); b_max = 8'(bm);
        @(negedge clk);
        go = 1'b0; a_max = 8'($urandom); b_max = 8'($urandom);
        chk("busy_after_go", busy, 1);
        chk("err_after_go", err, 0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        bit seen;
        d0   = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk({tag, "_busy_at_done"}, busy, 0);
        repeat (3) @(negedge clk);
        chk({tag, "_done_pulses"}, done_cnt - d0, 1);
        chk({tag, "_busy_idle"}, busy, 0);
        chk({tag, "_all_issued"}, op_q.size(), 0);
    endtask

    task automatic drain();
        rd_pct = 100;
        rd_budget = 1000;
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge clk);
        rd_budget = 0;
        @(negedge clk);
        chk("drain_count", count, 0);
        chk("drain_valid", rd_valid, 0);
        chk("drain_rd_data", rd_data, 0);
        chk("drain_ref_empty", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int am, bm, s0, sb, dc, c0;

    initial begin
        rst = 1'b1; go = 1'b0; a_max = 8'd0; b_max = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cy_start", cy_start, 0);
        chk("rst_cy_a", cy_a, 0);
        chk("rst_cy_b", cy_b, 0);
        chk("rst_count", count, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        rst = 1'b0;

        // Pops on an empty FIFO are ignored.
        rd_pct = 100; rd_budget = 1000;
        repeat (5) @(negedge clk);
        chk("empty_pop_count", count, 0);
        chk("empty_pop_valid", rd_valid, 0);
        rd_budget = 0;

        // 3x3 sweep with a draining reader; go pulses while busy must not start anything.
        lat = 3; iv_chk = 1'b1; y_force = -1;
        sb = starts;
        load_sweep(2, 2, 1'b1);
        rd_pct = 100; rd_budget = 1000;
        start_sweep(2, 2);
        @(negedge clk); go = 1'b1; a_max = 8'd5; b_max = 8'd5;
        @(negedge clk); go = 1'b0;
        repeat (10) @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        wait_done("s9", 300);
        chk("s9_entry8", last_pop, {8'd2, 8'd2, 8'd5});
        chk("s9_starts", starts - sb, 9);
        repeat (10) @(negedge clk);
        chk("s9_no_second_sweep", starts - sb, 9);
        drain();

        // Single point, compute_y answers 7 after 5 cycles, no reader.
        lat = 5; y_force = 7;
        sb = starts;
        load_sweep(0, 0, 1'b1);
        start_sweep(0, 0);
        wait_done("s1", 100);
        chk("s1_starts", starts - sb, 1);
        chk("s1_rd_data", rd_data, {8'd0, 8'd0, 8'd7});
        chk("s1_count", count, 1);
        y_force = -1;
        drain();

        // 32 points into a 16-deep FIFO with no reader: stall, then release with 16 pops.
        lat = 2; iv_chk = 1'b0;
        sb = starts;
        load_sweep(3, 7, 1'b1);
        start_sweep(3, 7);
        for (int i = 0; i < 400 && count != 5'd16; i++) @(negedge clk);
        chk("stall_full", count, 16);
        repeat (10) @(negedge clk);
        s0 = starts;
        chk("stall_starts", starts - sb, 17);
        repeat (20) @(negedge clk);
        chk("stall_no_start", starts, s0);
        chk("stall_count", count, 16);
        chk("stall_busy", busy, 1);
        rd_pct = 100; rd_budget = 16;
        wait_done("s32", 400);
        chk("s32_count", count, 16);
        chk("s32_starts", starts - sb, 32);
        drain();

        // Reset after the 3rd point, then a fresh sweep restarts from (0,0).
        lat = 2; iv_chk = 1'b1;
        load_sweep(2, 2, 1'b1);
        start_sweep(2, 2);
        for (int i = 0; i < 200 && count != 5'd3; i++) @(negedge clk);
        chk("rst_mid_pre_count", count, 3);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_count", count, 0);
        chk("rst_mid_cy_start", cy_start, 0);
        chk("rst_mid_rd_valid", rd_valid, 0);
        chk("rst_mid_cy_a", cy_a, 0);
        chk("rst_mid_cy_b", cy_b, 0);
        rst = 1'b0;
        op_q.delete();
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk("rst_mid_quiet_count", count, 0);
        load_sweep(2, 2, 1'b1);
        rd_pct = 100; rd_budget = 1000;
        start_sweep(2, 2);
        wait_done("restart", 300);
        drain();

        // FIFO contents survive IDLE; a second sweep appends.
        lat = 1; rd_budget = 0;
        load_sweep(1, 1, 1'b1);
        start_sweep(1, 1);
        wait_done("app1", 100);
        load_sweep(0, 2, 1'b1);
        start_sweep(0, 2);
        wait_done("app2", 100);
        chk("append_count", count, 7);
        drain();

        // Randomized sweeps with random latency and reader pressure.
        for (int k = 0; k < 6; k++) begin
            am  = $urandom_range(0, 3);
            bm  = $urandom_range(0, 3);
            lat = $urandom_range(1, 6);
            rd_pct = $urandom_range(20, 100);
            rd_budget = 1000;
            load_sweep(am, bm, 1'b1);
            start_sweep(am, bm);
            wait_done("rand", 400);
            drain();
        end

`ifdef COMPUTE_Y_SEQ_TIMEOUT_EN
        // compute_y never answers: abort after TIMEOUT WAIT cycles, nothing stored.
        no_resp = 1'b1; iv_chk = 1'b0;
        c0 = int'(count);
        op_q.push_back(16'h0000);
        start_sweep(0, 0);
        dc = -1;
        for (int i = 0; i < 60 && dc < 0; i++) begin
            @(negedge clk);
            if (done) dc = cyc;
        end
        chk("to_done_cycles", dc - last_start, 9);
        chk("to_err", err, 1);
        chk("to_count", count, c0);
        chk("to_busy", busy, 0);
        repeat (5) @(negedge clk);
        chk("to_err_sticky", err, 1);
        no_resp = 1'b0;
        load_sweep(0, 0, 1'b1);
        start_sweep(0, 0);
        wait_done("to_recover", 100);
        drain();
`else
        chk("err_tied_low", err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/compute_y_sequencer.md
COMPUTE_Y_SEQUENCER -- requirements
Module: compute_y_sequencer

Interface
REQ-001 Parameter DEPTH, default 16, result FIFO depth in entries (power of two).
REQ-002 Parameter TIMEOUT, default 1024, maximum WAIT cycles before abort (used only when COMPUTE_Y_SEQ_TIMEOUT_EN is defined).
REQ-003 clk  input  1  clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 go  input  1  sweep request, sampled in IDLE only.
REQ-006 a_max  input  8  last a value of the sweep, latched on accepted go.
REQ-007 b_max  input  8  last b value of the sweep, latched on accepted go.
REQ-008 busy  output  1  high from the cycle after an accepted go until return to IDLE.
REQ-009 done  output  1  one-cycle pulse when the sweep ends, normally or on abort.
REQ-010 err  output  1  sticky timeout flag, cleared on the next accepted go.
REQ-011 cy_start  output  1  one-cycle start pulse to the compute_y stage.
REQ-012 cy_a, cy_b  output  8 each  operands to compute_y, held stable from cy_start until cy_ready.
REQ-013 cy_y  input  8  compute_y result, valid in the cycle cy_ready is high.
REQ-014 cy_ready  input  1  compute_y one-cycle completion pulse.
REQ-015 rd_en  input  1  FIFO pop request.
REQ-016 rd_data  output  24  FIFO head {a[23:16], b[15:8], y[7:0]}, first-word fall-through.
REQ-017 rd_valid  output  1  high when the FIFO is non-empty.
REQ-018 count  output  log2(DEPTH)+1  current FIFO occupancy.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT, STORE, NEXT.
- IDLE: go=1 -> latch a_max/b_max, cy_a=0, cy_b=0, clear err -> ISSUE.
- ISSUE: cy_start=1 for exactly this cycle -> WAIT.
- WAIT: cy_ready=1 -> capture cy_y -> STORE.
- STORE: push when count<DEPTH -> NEXT; otherwise hold in STORE (stall).
- NEXT: if cy_b==b_max and cy_a==a_max -> pulse done -> IDLE; else if cy_b==b_max -> cy_b=0, cy_a+1 -> ISSUE; else cy_b+1 -> ISSUE.
REQ-020 A sweep SHALL produce exactly (a_max+1)*(b_max+1) FIFO entries, in b-fastest order.
REQ-021 go asserted outside IDLE SHALL be ignored.
REQ-022 cy_ready outside WAIT SHALL be ignored.
REQ-023 Minimum cycles per point, FIFO not full: ISSUE + WAIT + STORE + NEXT, i.e. 3 + compute_y latency.
REQ-024 rd_en while the FIFO is empty SHALL be ignored; count does not underflow.
REQ-025 A simultaneous push and pop on a non-empty, non-full FIFO SHALL leave count unchanged; a pop while full SHALL free space for a push no earlier than the next cycle.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH.
REQ-027 FIFO contents SHALL survive return to IDLE; a new sweep appends to existing entries.
REQ-028 a_max=0, b_max=0 SHALL produce exactly one point.
REQ-029 a_max=255, b_max=255 SHALL terminate with 65536 points and no counter overflow.

Reset
REQ-030 While rst is high, the block SHALL be held in: state IDLE; busy, done, err, cy_start = 0; cy_a, cy_b = 0; FIFO emptied (count=0, rd_valid=0, pointers=0); rd_data = 0.
REQ-031 rst mid-sweep SHALL abort immediately, with no further cy_start; compute_y shares the same rst.

Configuration
REQ-032 With COMPUTE_Y_SEQ_TIMEOUT_EN defined:
- A counter SHALL run in WAIT.
- On TIMEOUT cycles without cy_ready: set err=1, pulse done, go to IDLE; the point is not stored.
REQ-033 Without COMPUTE_Y_SEQ_TIMEOUT_EN: WAIT SHALL wait indefinitely, err is tied to 0, and no counter is synthesized.

Verification
REQ-034 Sweep go with a_max=2, b_max=2, model compute_y (y=a*a+cbrt(b)), reader draining -> 9 entries in order; entry 8 = {2,2,5}; done pulses once; busy then falls.
REQ-035 Sweep a_max=0, b_max=0, model returns y=7 after 5 cycles -> cy_start seen once; rd_data={0,0,7}; count=1.
REQ-036 Sweep a_max=3, b_max=7 (32 points), DEPTH=16, no reads -> stall in STORE at count=16 with no cy_start; after 16 pops the sweep completes with count=16.
REQ-037 Assert rst after the 3rd point of a 9-point sweep -> next cycle busy=0, count=0, cy_start=0; a new go restarts from a=0, b=0.
REQ-038 Macro defined, TIMEOUT=8, model never returns cy_ready -> err=1 and done pulse exactly 8 cycles after entering WAIT; count unchanged; the next go clears err.
REQ-039 rd_en with the FIFO empty, and go pulsed while busy -> count stays 0, and no second sweep starts.
